// File: rtl/disparity_wta.sv
// Winner-take-all disparity selection: min-tree over NUM_DISP costs with a uniqueness/saturation check.
// Fixed 8-cycle latency, free-running with no backpressure; data stages update every cycle, only valid_out qualifies.
module disparity_wta #(
    parameter int COST_WIDTH = 9,
    parameter int NUM_DISP   = 96,
    parameter int DIM_WIDTH  = 10,
    parameter int UNIQ_RATIO = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_DISP*COST_WIDTH-1:0]   cost_in,
    input  logic [DIM_WIDTH-1:0]             row_in,
    input  logic [DIM_WIDTH-1:0]             col_in,
    input  logic                             valid_in,
    output logic [6:0]                       disp_out,
    output logic [COST_WIDTH-1:0]            cost_out,
    output logic                             disp_ok,
    output logic [DIM_WIDTH-1:0]             row_out,
    output logic [DIM_WIDTH-1:0]             col_out,
    output logic                             valid_out
);
    localparam int IW    = 7;
    localparam int DEPTH = 8;
    // Wide enough for cost * 200 without truncation.
    localparam int PW    = COST_WIDTH + 9;
    localparam logic [COST_WIDTH-1:0] SAT = '1;

    typedef struct packed {
        logic [COST_WIDTH-1:0] min1;
        logic [IW-1:0]         idx1;
        logic [COST_WIDTH-1:0] min2;
    } node_t;

    // A always covers the lower indices, so '<=' resolves ties toward the lower disparity.
    function automatic node_t merge(input node_t a, input node_t b);
        node_t w;
        node_t l;
        node_t r;
        if (a.min1 <= b.min1) begin
            w = a;
            l = b;
        end else begin
            w = b;
            l = a;
        end
        r      = w;
        r.min2 = (l.min1 < w.min2) ? l.min1 : w.min2;
        return r;
    endfunction

    node_t s1_d [48];
    node_t s1_q [48];
    node_t s2_d [24];
    node_t s2_q [24];
    node_t s3_d [12];
    node_t s3_q [12];
    node_t s4_d [6];
    node_t s4_q [6];
    node_t s5_d [3];
    node_t s5_q [3];
    node_t s6_d [2];
    node_t s6_q [2];
    node_t s7_d;
    node_t s7_q;

    always_comb begin
        node_t la;
        node_t lb;
        la = '0;
        lb = '0;
        for (int i = 0; i < 48; i++) begin
            la.min1  = cost_in[(2*i)*COST_WIDTH +: COST_WIDTH];
            la.idx1  = IW'(2*i);
            la.min2  = SAT;
            lb.min1  = cost_in[(2*i+1)*COST_WIDTH +: COST_WIDTH];
            lb.idx1  = IW'(2*i+1);
            lb.min2  = SAT;
            s1_d[i]  = merge(la, lb);
        end
    end

    always_comb begin
        for (int i = 0; i < 24; i++) s2_d[i] = merge(s1_q[2*i], s1_q[2*i+1]);
        for (int i = 0; i < 12; i++) s3_d[i] = merge(s2_q[2*i], s2_q[2*i+1]);
        for (int i = 0; i < 6; i++)  s4_d[i] = merge(s3_q[2*i], s3_q[2*i+1]);
        for (int i = 0; i < 3; i++)  s5_d[i] = merge(s4_q[2*i], s4_q[2*i+1]);
        s6_d[0] = merge(s5_q[0], s5_q[1]);
        s6_d[1] = s5_q[2];
        s7_d    = merge(s6_q[0], s6_q[1]);
    end

    always_ff @(posedge clk) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
        s3_q <= s3_d;
        s4_q <= s4_d;
        s5_q <= s5_d;
        s6_q <= s6_d;
        s7_q <= s7_d;
    end

    logic [IW-1:0]         disp_d;
    logic [IW-1:0]         disp_q;
    logic [COST_WIDTH-1:0] cost_d;
    logic [COST_WIDTH-1:0] cost_q;
    logic                  ok_d;
    logic                  ok_q;
    logic [PW-1:0]         prod1;
    logic [PW-1:0]         prod2;

    always_comb begin
        prod1  = PW'(s7_q.min1) * PW'(100 + UNIQ_RATIO);
        prod2  = PW'(s7_q.min2) * PW'(100);
        disp_d = s7_q.idx1;
        cost_d = s7_q.min1;
        ok_d   = (prod2 > prod1) && (s7_q.min1 != SAT) && (s7_q.min1 != s7_q.min2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= '0;
            cost_q <= SAT;
            ok_q   <= 1'b0;
        end else begin
            disp_q <= disp_d;
            cost_q <= cost_d;
            ok_q   <= ok_d;
        end
    end

    logic [DEPTH-1:0]     vld_d;
    logic [DEPTH-1:0]     vld_q;
    logic [DIM_WIDTH-1:0] row_d [DEPTH];
    logic [DIM_WIDTH-1:0] row_q [DEPTH];
    logic [DIM_WIDTH-1:0] col_d [DEPTH];
    logic [DIM_WIDTH-1:0] col_q [DEPTH];

    always_comb begin
        vld_d    = {vld_q[DEPTH-2:0], valid_in};
        row_d[0] = row_in;
        col_d[0] = col_in;
        for (int i = 1; i < DEPTH; i++) begin
            row_d[i] = row_q[i-1];
            col_d[i] = col_q[i-1];
        end
    end

    // Clearing every valid bit drops all pixels in flight on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                row_q[i] <= '0;
                col_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign disp_out  = disp_q;
    assign cost_out  = cost_q;
    assign disp_ok   = ok_q;
    assign row_out   = row_q[DEPTH-1];
    assign col_out   = col_q[DEPTH-1];
    assign valid_out = vld_q[DEPTH-1];
endmodule

// File: tb/tb_disparity_wta.sv
// Scoreboard bench for disparity_wta: random and directed cost vectors against a plain min-search reference.
module tb_disparity_wta;
    localparam int CW = 9;
    localparam int ND = 96;
    localparam int DW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [ND*CW-1:0] cost_in;
    logic [DW-1:0]    row_in;
    logic [DW-1:0]    col_in;
    logic             valid_in;
    logic [6:0]       disp_out;
    logic [CW-1:0]    cost_out;
    logic             disp_ok;
    logic [DW-1:0]    row_out;
    logic [DW-1:0]    col_out;
    logic             valid_out;

    disparity_wta #(.COST_WIDTH(CW), .NUM_DISP(ND), .DIM_WIDTH(DW), .UNIQ_RATIO(10)) dut (
        .clk(clk), .rst(rst), .cost_in(cost_in), .row_in(row_in), .col_in(col_in),
        .valid_in(valid_in), .disp_out(disp_out), .cost_out(cost_out), .disp_ok(disp_ok),
        .row_out(row_out), .col_out(col_out), .valid_out(valid_out)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int disp;
        int cost;
        int ok;
        int row;
        int col;
        int due;
    } exp_t;

    exp_t sb[$];
    int   costs[ND];

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Winner = first index holding the minimum; runner-up = minimum over every other index.
    function automatic exp_t model();
        exp_t e;
        int m1 = costs[0];
        int i1 = 0;
        int m2 = 1 << 20;
        for (int d = 1; d < ND; d++) if (costs[d] < m1) begin m1 = costs[d]; i1 = d; end
        for (int d = 0; d < ND; d++) if (d != i1 && costs[d] < m2) m2 = costs[d];
        e.disp = i1;
        e.cost = m1;
        e.ok   = (m1 != 511 && m1 != m2 && m2 * 100 > m1 * 110) ? 1 : 0;
        e.row  = 0;
        e.col  = 0;
        e.due  = 0;
        return e;
    endfunction

    task automatic fill(input int v);
        for (int d = 0; d < ND; d++) costs[d] = v;
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int d = 0; d < ND; d++) costs[d] = int'($urandom_range(hi, lo));
    endtask

    task automatic send(input int r, input int c);
        exp_t e;
        for (int d = 0; d < ND; d++) cost_in[d*CW +: CW] = CW'(costs[d]);
        row_in   = DW'(r);
        col_in   = DW'(c);
        valid_in = 1'b1;
        e        = model();
        e.row    = r;
        e.col    = c;
        e.due    = cyc + 8;
        sb.push_back(e);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_disp_out", int'(disp_out), 0);
        chk("rst_cost_out", int'(cost_out), 511);
        chk("rst_disp_ok", int'(disp_ok), 0);
        chk("rst_row_out", int'(row_out), 0);
        chk("rst_col_out", int'(col_out), 0);
    endtask

    always @(negedge clk) begin
        if (valid_out) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid_out: got col %0d, expected no output", col_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc, e.due);
                chk("disp_out", int'(disp_out), e.disp);
                chk("cost_out", int'(cost_out), e.cost);
                chk("disp_ok", int'(disp_ok), e.ok);
                chk("row_out", int'(row_out), e.row);
                chk("col_out", int'(col_out), e.col);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        cost_in  = '0;
        row_in   = '0;
        col_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;

        // Directed cases: clear winner, tie, uniqueness margin both sides, saturation, edges.
        fill(200); costs[37] = 50;  send(1, 1);
        fill(300); costs[10] = 40; costs[80] = 40; send(2, 2);
        fill(108); costs[5] = 100; send(3, 3);
        fill(111); costs[5] = 100; send(4, 4);
        fill(511); send(5, 5);
        fill(0);   send(6, 6);
        fill(400); costs[95] = 3; send(7, 7);
        fill(511); costs[0] = 510; send(8, 8);
        idle(12);

        for (int k = 0; k < 20; k++) begin
            case (k % 3)
                0:       fill_rand(0, 511);
                1:       fill_rand(100, 112);
                default: fill_rand(490, 511);
            endcase
            send(9, k);
        end
        idle(12);

        for (int k = 0; k < 30; k++) begin
            fill_rand(int'($urandom_range(300, 0)), 511);
            send(int'($urandom_range(1023, 0)), 100 + k);
            idle(int'($urandom_range(2, 0)));
        end
        idle(12);

        // Five pixels in flight, then reset: none of them may appear.
        for (int k = 0; k < 5; k++) begin
            fill_rand(0, 511);
            send(11, 200 + k);
        end
        idle(2);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        fill(250); costs[60] = 20;
        send(12, 300);
        idle(15);
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
